// File: rtl/axi_sdram_bist_master.sv
// AXI4 write-then-read BIST initiator for the AxiToSdram slave port.
// Writes an incrementing seeded pattern in one INCR burst, reads it back and counts mismatches.
module axi_sdram_bist_master #(
  parameter logic [3:0]  P_ID   = 4'b0000,
  parameter int unsigned P_ERRW = 16
) (
  input  logic              AxiClk,
  input  logic              AxiRest,
  // control and status
  input  logic              Start,
  input  logic [31:0]       BaseAddr,
  input  logic [8:0]        BurstLen,
  input  logic [31:0]       Seed,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              ParamErr,
  output logic [P_ERRW-1:0] ErrCnt,
  output logic [31:0]       FirstErrAddr,
  // write address
  output logic [3:0]        AwidMaster,
  output logic [31:0]       AwaddrMaster,
  output logic [7:0]        AwlenMaster,
  output logic [2:0]        AwsizeMaster,
  output logic [1:0]        AwburstMaster,
  output logic              AwlockMaster,
  output logic [3:0]        AwcacheMaster,
  output logic [2:0]        AwportMaster,
  output logic              AwvalidMaster,
  input  logic              AwreadyMaster,
  // write data
  output logic [3:0]        WidMaster,
  output logic [31:0]       WdataMaster,
  output logic [3:0]        WstrbMaster,
  output logic              WlastMaster,
  output logic              WvalidMaster,
  input  logic              WreadyMaster,
  // write response
  input  logic [3:0]        BidMaster,
  input  logic [1:0]        BrespMaster,
  input  logic              BvalidMaster,
  output logic              BreadyMaster,
  // read address
  output logic [3:0]        AridMaster,
  output logic [31:0]       AraddrMaster,
  output logic [7:0]        ArlenMaster,
  output logic [2:0]        ArsizeMaster,
  output logic [1:0]        ArburstMaster,
  output logic              ArlockMaster,
  output logic [3:0]        ArcacheMaster,
  output logic [2:0]        ArportMaster,
  output logic              ArvalidMaster,
  input  logic              ArreadyMaster,
  // read data
  input  logic [3:0]        RidMaster,
  input  logic [31:0]       RdataMaster,
  input  logic [1:0]        RrespMaster,
  input  logic              RlastMaster,
  input  logic              RvalidMaster,
  output logic              RreadyMaster
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StAr   = 3'd4;
  localparam logic [2:0] StR    = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  logic [2:0]        state;
  logic [31:0]       addrQ;
  logic [7:0]        lenQ;
  logic [31:0]       seedQ;
  logic [7:0]        beat;
  logic [P_ERRW-1:0] errCnt;
  logic [31:0]       firstErr;
  logic              firstSeen;
  logic              passQ;
  logic              paramErrQ;
  logic              fieldsOn;
  logic              awValid;
  logic              wValid;
  logic [31:0]       wData;
  logic              wLast;
  logic              bReady;
  logic              arValid;
  logic              rReady;

  logic [8:0]        lenM1;
  logic [12:0]       endOffset;
  logic              startOk;
  logic [31:0]       expData;
  logic              rMismatch;
  logic              errInc;
  logic [P_ERRW-1:0] errCntNext;
  logic              unusedBits;

  assign lenM1     = BurstLen - 9'd1;
  // Burst end relative to its 4 KB page; exactly 4096 still fits.
  assign endOffset = {1'b0, BaseAddr[11:2], 2'b00} + {2'b00, BurstLen, 2'b00};
  assign startOk   = (BurstLen != 9'd0) && (BurstLen <= 9'd256) && (endOffset <= 13'd4096);

  assign expData   = seedQ + {24'b0, beat};
  assign rMismatch = (RdataMaster != expData) || (RrespMaster != 2'b00) ||
                     (RlastMaster != (beat == lenQ));
  assign errInc    = ((state == StB) && BvalidMaster && (BrespMaster != 2'b00)) ||
                     ((state == StR) && RvalidMaster && rMismatch);
  assign errCntNext = (errInc && !(&errCnt)) ? errCnt + P_ERRW'(1) : errCnt;

  assign unusedBits = ^{BidMaster, RidMaster, BaseAddr[1:0], lenM1[8]};

  always_ff @(posedge AxiClk or negedge AxiRest) begin
    if (!AxiRest) begin
      state     <= StIdle;
      addrQ     <= '0;
      lenQ      <= '0;
      seedQ     <= '0;
      beat      <= '0;
      errCnt    <= '0;
      firstErr  <= '0;
      firstSeen <= 1'b0;
      passQ     <= 1'b0;
      paramErrQ <= 1'b0;
      fieldsOn  <= 1'b0;
      awValid   <= 1'b0;
      wValid    <= 1'b0;
      wData     <= '0;
      wLast     <= 1'b0;
      bReady    <= 1'b0;
      arValid   <= 1'b0;
      rReady    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (Start) begin
            errCnt    <= '0;
            passQ     <= 1'b0;
            firstErr  <= '0;
            firstSeen <= 1'b0;
            if (startOk) begin
              paramErrQ <= 1'b0;
              addrQ     <= {BaseAddr[31:2], 2'b00};
              lenQ      <= lenM1[7:0];
              seedQ     <= Seed;
              fieldsOn  <= 1'b1;
              awValid   <= 1'b1;
              state     <= StAw;
            end else begin
              paramErrQ <= 1'b1;
              state     <= StDone;
            end
          end
        end
        StAw: begin
          if (AwreadyMaster) begin
            awValid <= 1'b0;
            wValid  <= 1'b1;
            wData   <= seedQ;
            wLast   <= (lenQ == 8'd0);
            beat    <= '0;
            state   <= StW;
          end
        end
        StW: begin
          if (WreadyMaster) begin
            if (wLast) begin
              wValid <= 1'b0;
              wLast  <= 1'b0;
              bReady <= 1'b1;
              state  <= StB;
            end else begin
              beat  <= beat + 8'd1;
              wData <= wData + 32'd1;
              wLast <= ((beat + 8'd1) == lenQ);
            end
          end
        end
        StB: begin
          if (BvalidMaster) begin
            errCnt  <= errCntNext;
            bReady  <= 1'b0;
            arValid <= 1'b1;
            state   <= StAr;
          end
        end
        StAr: begin
          if (ArreadyMaster) begin
            arValid <= 1'b0;
            rReady  <= 1'b1;
            beat    <= '0;
            state   <= StR;
          end
        end
        StR: begin
          if (RvalidMaster) begin
            errCnt <= errCntNext;
            beat   <= beat + 8'd1;
            if (rMismatch && !firstSeen) begin
              firstSeen <= 1'b1;
              firstErr  <= addrQ + {22'b0, beat, 2'b00};
            end
            // Only the beat count ends the burst; RlastMaster is merely checked.
            if (beat == lenQ) begin
              rReady <= 1'b0;
              passQ  <= (errCntNext == '0);
              state  <= StDone;
            end
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign Busy         = (state != StIdle);
  assign Done         = (state == StDone);
  assign Pass         = passQ;
  assign ParamErr     = paramErrQ;
  assign ErrCnt       = errCnt;
  assign FirstErrAddr = firstErr;

  assign AwidMaster    = P_ID;
  assign AwaddrMaster  = addrQ;
  assign AwlenMaster   = lenQ;
  assign AwsizeMaster  = fieldsOn ? 3'b010 : 3'b000;
  assign AwburstMaster = fieldsOn ? 2'b01 : 2'b00;
  assign AwlockMaster  = 1'b0;
  assign AwcacheMaster = fieldsOn ? 4'b0010 : 4'b0000;
  assign AwportMaster  = 3'b000;
  assign AwvalidMaster = awValid;

  assign WidMaster     = P_ID;
  assign WdataMaster   = wData;
  assign WstrbMaster   = wValid ? 4'hF : 4'h0;
  assign WlastMaster   = wLast;
  assign WvalidMaster  = wValid;

  assign BreadyMaster  = bReady;

  assign AridMaster    = P_ID;
  assign AraddrMaster  = addrQ;
  assign ArlenMaster   = lenQ;
  assign ArsizeMaster  = AwsizeMaster;
  assign ArburstMaster = AwburstMaster;
  assign ArlockMaster  = 1'b0;
  assign ArcacheMaster = AwcacheMaster;
  assign ArportMaster  = 3'b000;
  assign ArvalidMaster = arValid;

  assign RreadyMaster  = rReady;

endmodule

// File: tb/tb_axi_sdram_bist_master.sv
// Bench for axi_sdram_bist_master: memory-backed AXI slave model with random throttling,
// injected read corruption / write-response errors, and expected results from the pattern rules.
module tb_axi_sdram_bist_master;

  logic        AxiClk = 1'b0;
  logic        AxiRest = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] BaseAddr = '0;
  logic [8:0]  BurstLen = '0;
  logic [31:0] Seed = '0;
  logic        Busy, Done, Pass, ParamErr;
  logic [15:0] ErrCnt;
  logic [31:0] FirstErrAddr;
  logic [3:0]  AwidMaster, AwcacheMaster, WidMaster, WstrbMaster, AridMaster, ArcacheMaster;
  logic [31:0] AwaddrMaster, AraddrMaster, WdataMaster;
  logic [7:0]  AwlenMaster, ArlenMaster;
  logic [2:0]  AwsizeMaster, AwportMaster, ArsizeMaster, ArportMaster;
  logic [1:0]  AwburstMaster, ArburstMaster;
  logic        AwlockMaster, AwvalidMaster, WlastMaster, WvalidMaster, BreadyMaster;
  logic        ArlockMaster, ArvalidMaster, RreadyMaster;
  logic        AwreadyMaster = 1'b0, WreadyMaster = 1'b0, ArreadyMaster = 1'b0;
  logic [3:0]  BidMaster = '0, RidMaster = '0;
  logic [1:0]  BrespMaster = '0, RrespMaster = '0;
  logic        BvalidMaster = 1'b0, RvalidMaster = 1'b0, RlastMaster = 1'b0;
  logic [31:0] RdataMaster = '0;

  always #5 AxiClk = ~AxiClk;

  axi_sdram_bist_master #(.P_ID(4'b0000), .P_ERRW(16)) dut (
    .AxiClk(AxiClk), .AxiRest(AxiRest), .Start(Start), .BaseAddr(BaseAddr),
    .BurstLen(BurstLen), .Seed(Seed), .Busy(Busy), .Done(Done), .Pass(Pass),
    .ParamErr(ParamErr), .ErrCnt(ErrCnt), .FirstErrAddr(FirstErrAddr),
    .AwidMaster(AwidMaster), .AwaddrMaster(AwaddrMaster), .AwlenMaster(AwlenMaster),
    .AwsizeMaster(AwsizeMaster), .AwburstMaster(AwburstMaster), .AwlockMaster(AwlockMaster),
    .AwcacheMaster(AwcacheMaster), .AwportMaster(AwportMaster),
    .AwvalidMaster(AwvalidMaster), .AwreadyMaster(AwreadyMaster),
    .WidMaster(WidMaster), .WdataMaster(WdataMaster), .WstrbMaster(WstrbMaster),
    .WlastMaster(WlastMaster), .WvalidMaster(WvalidMaster), .WreadyMaster(WreadyMaster),
    .BidMaster(BidMaster), .BrespMaster(BrespMaster), .BvalidMaster(BvalidMaster),
    .BreadyMaster(BreadyMaster),
    .AridMaster(AridMaster), .AraddrMaster(AraddrMaster), .ArlenMaster(ArlenMaster),
    .ArsizeMaster(ArsizeMaster), .ArburstMaster(ArburstMaster), .ArlockMaster(ArlockMaster),
    .ArcacheMaster(ArcacheMaster), .ArportMaster(ArportMaster),
    .ArvalidMaster(ArvalidMaster), .ArreadyMaster(ArreadyMaster),
    .RidMaster(RidMaster), .RdataMaster(RdataMaster), .RrespMaster(RrespMaster),
    .RlastMaster(RlastMaster), .RvalidMaster(RvalidMaster), .RreadyMaster(RreadyMaster)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Slave model state and test expectations
  logic [31:0] mem [int unsigned];
  bit          corrupt [256];
  int          thr = 1;
  bit          bErrInj = 0;
  logic [31:0] expSeed = '0, expBase = '0;
  int          expLen = 1;
  int          awCnt = 0, arCnt = 0, wHs = 0, rHs = 0, wErr = 0, protoErr = 0, dropErr = 0;
  int          wBeat = 0, rBeat = 0, rRemain = 0;
  bit          inBurst = 0, bPending = 0;
  logic [31:0] wAddr = '0, rAddr = '0;

  always @(posedge AxiClk) begin
    if (!AxiRest) begin
      wBeat = 0; rRemain = 0; bPending = 0; inBurst = 0;
    end else begin
      if (inBurst && !WvalidMaster) dropErr++;
      if (AwvalidMaster && AwreadyMaster) begin
        awCnt++;
        wAddr = AwaddrMaster; wBeat = 0; inBurst = 1;
        if (AwaddrMaster !== expBase || AwlenMaster !== 8'(expLen - 1) ||
            AwsizeMaster !== 3'b010 || AwburstMaster !== 2'b01 ||
            AwcacheMaster !== 4'b0010 || WvalidMaster) protoErr++;
      end else if (WvalidMaster && !inBurst) protoErr++;
      if (WvalidMaster && WreadyMaster && inBurst) begin
        if (WdataMaster !== expSeed + 32'(wBeat) || WlastMaster !== (wBeat == expLen - 1) ||
            WstrbMaster !== 4'hF) wErr++;
        mem[(wAddr >> 2) + 32'(wBeat)] = WdataMaster;
        wBeat++; wHs++;
        if (wBeat == expLen) begin inBurst = 0; bPending = 1; end
      end
      if (BvalidMaster && BreadyMaster) bPending = 0;
      if (ArvalidMaster && ArreadyMaster) begin
        arCnt++;
        rAddr = AraddrMaster; rBeat = 0; rRemain = int'(ArlenMaster) + 1;
        if (AraddrMaster !== expBase || ArlenMaster !== 8'(expLen - 1) ||
            ArsizeMaster !== 3'b010 || ArburstMaster !== 2'b01) protoErr++;
      end
      if (RvalidMaster && RreadyMaster) begin rBeat++; rRemain--; rHs++; end
    end
  end

  always @(negedge AxiClk) begin
    if (!AxiRest) begin
      AwreadyMaster = 0; WreadyMaster = 0; ArreadyMaster = 0;
      BvalidMaster = 0; RvalidMaster = 0; RlastMaster = 0;
    end else begin
      AwreadyMaster = ($urandom_range(thr - 1) == 0);
      WreadyMaster  = ($urandom_range(thr - 1) == 0);
      ArreadyMaster = ($urandom_range(thr - 1) == 0);
      BvalidMaster  = bPending && (BvalidMaster || ($urandom_range(thr - 1) == 0));
      BrespMaster   = bErrInj ? 2'b10 : 2'b00;
      RvalidMaster  = (rRemain > 0) && (RvalidMaster || ($urandom_range(thr - 1) == 0));
      if (rRemain > 0) begin
        RdataMaster = mem[(rAddr >> 2) + 32'(rBeat)] ^ (corrupt[rBeat] ? 32'h100 : 32'h0);
        RlastMaster = (rRemain == 1);
      end else RlastMaster = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulseStart(input logic [31:0] base, input int len, input logic [31:0] seed);
    @(negedge AxiClk);
    BaseAddr = base; BurstLen = len[8:0]; Seed = seed; Start = 1;
    @(negedge AxiClk);
    Start = 0;
  endtask

  task automatic prep(input logic [31:0] base, input int len, input logic [31:0] seed,
                      input int throttle, input bit bErr);
    expBase = {base[31:2], 2'b00}; expLen = len; expSeed = seed; thr = throttle;
    bErrInj = bErr;
    awCnt = 0; arCnt = 0; wHs = 0; rHs = 0; wErr = 0; protoErr = 0; dropErr = 0;
  endtask

  task automatic runTest(input logic [31:0] base, input int len, input logic [31:0] seed,
                         input int throttle, input bit bErr);
    int errExp; logic [31:0] firstExp; bit found; bit got;
    prep(base, len, seed, throttle, bErr);
    errExp = int'(bErr); firstExp = '0; found = 0; got = 0;
    for (int i = 0; i < len; i++) if (corrupt[i]) begin
      errExp++;
      if (!found) firstExp = expBase + 32'(4 * i);
      found = 1;
    end
    pulseStart(base, len, seed);
    for (int c = 0; c < 20 * len + 200; c++) begin
      if (Done === 1'b1) begin got = 1; break; end
      @(negedge AxiClk);
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("busy_at_done", 32'(Busy), 32'd1);
      check("pass", 32'(Pass), 32'(errExp == 0));
      check("err_cnt", 32'(ErrCnt), 32'(errExp));
      check("first_err_addr", FirstErrAddr, firstExp);
      check("param_err", 32'(ParamErr), 32'd0);
      check("w_handshakes", 32'(wHs), 32'(len));
      check("r_handshakes", 32'(rHs), 32'(len));
      check("w_data_errs", 32'(wErr), 32'd0);
      check("addr_proto_errs", 32'(protoErr), 32'd0);
      check("w_valid_drops", 32'(dropErr), 32'd0);
      check("aw_count", 32'(awCnt), 32'd1);
      check("ar_count", 32'(arCnt), 32'd1);
      @(negedge AxiClk);
      check("done_pulse_width", 32'(Done), 32'd0);
      check("busy_after", 32'(Busy), 32'd0);
      check("pass_held", 32'(Pass), 32'(errExp == 0));
    end
    foreach (corrupt[i]) corrupt[i] = 0;
  endtask

  task automatic rejectTest(input logic [31:0] base, input int len);
    prep(base, len, 32'h0, 1, 0);
    pulseStart(base, len, 32'h1234);
    check("rej_done", 32'(Done), 32'd1);
    check("rej_param_err", 32'(ParamErr), 32'd1);
    check("rej_pass", 32'(Pass), 32'd0);
    check("rej_err_cnt", 32'(ErrCnt), 32'd0);
    check("rej_awvalid", 32'(AwvalidMaster), 32'd0);
    @(negedge AxiClk);
    check("rej_done_drop", 32'(Done), 32'd0);
    check("rej_busy", 32'(Busy), 32'd0);
    check("rej_aw_count", 32'(awCnt), 32'd0);
    check("rej_param_held", 32'(ParamErr), 32'd1);
  endtask

  initial begin
    int len; logic [31:0] base; logic [31:0] r; bit got;
    foreach (corrupt[i]) corrupt[i] = 0;
    repeat (3) @(negedge AxiClk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_pass", 32'(Pass), 32'd0);
    check("rst_valids", {28'b0, AwvalidMaster, WvalidMaster, ArvalidMaster, WlastMaster}, 32'd0);
    check("rst_readies", {30'b0, BreadyMaster, RreadyMaster}, 32'd0);
    check("rst_awaddr", AwaddrMaster, 32'd0);
    check("rst_wdata", WdataMaster, 32'd0);
    check("rst_fields", {19'b0, AwlenMaster, AwsizeMaster, AwburstMaster}, 32'd0);
    check("rst_err", {ErrCnt, 15'b0, ParamErr}, 32'd0);
    check("rst_first_err", FirstErrAddr, 32'd0);
    AxiRest = 1;

    runTest(32'h0000_00F0, 1, 32'h0000_000A, 1, 0);
    runTest(32'h0000_00FC, 128, 32'h0000_0080, 3, 0);
    corrupt[5] = 1; corrupt[9] = 1;
    runTest(32'h0033_8000, 16, $urandom, 1, 0);
    rejectTest(32'h0000_0F00, 128);
    rejectTest(32'h0000_0100, 0);
    rejectTest(32'h1234_5C04, 256);
    runTest(32'h0000_0200, 4, 32'hFFFF_FFFE, 2, 1);
    runTest(32'h1234_5C00, 256, $urandom, 2, 0);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 64);
      r = $urandom;
      base = {r[31:12], 12'(4 * $urandom_range(0, 1024 - len))} | 32'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) corrupt[i] = ($urandom_range(0, 15) == 0);
      runTest(base, len, $urandom, $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a 99-beat write burst
    prep(32'h0000_0400, 99, 32'h5555_0000, 1, 0);
    pulseStart(32'h0000_0400, 99, 32'h5555_0000);
    got = 0;
    for (int c = 0; c < 400; c++) begin
      if (wHs >= 50) begin got = 1; break; end
      @(negedge AxiClk);
    end
    check("mid_reset_reach_beat50", 32'(got), 32'd1);
    AxiRest = 0;
    #1;
    check("mid_reset_valids", {29'b0, AwvalidMaster, WvalidMaster, ArvalidMaster}, 32'd0);
    check("mid_reset_busy", 32'(Busy), 32'd0);
    check("mid_reset_wlast_bready", {30'b0, WlastMaster, BreadyMaster}, 32'd0);
    check("mid_reset_wdata", WdataMaster, 32'd0);
    repeat (2) @(negedge AxiClk);
    AxiRest = 1;
    runTest(32'h0000_0400, 99, 32'h5555_0000, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
